uart_tx_scheduler: RTL

//   Shares one UART transmit line between NUM_REQ byte-stream requesters.

---
 rtl/uart_tx_scheduler.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin UART transmit scheduler: arbitrates NUM_REQ byte requesters, one frame per grant,
// and serializes the frame onto tx_o. Optional even parity bit with UART_TX_SCHED_PARITY_EN.
module uart_tx_scheduler #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned ID_W         = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic                          tx_o,
  output logic                          busy_o,
  output logic [ID_W-1:0]               grant_id_o,
  output logic                          frame_done_o
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] BAUD_TC = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_TC  = BW'(DATA_WIDTH - 1);

`ifdef UART_TX_SCHED_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t                  state;
  logic [ID_W-1:0]         rr;
  logic [CW-1:0]           baud;
  logic [BW-1:0]           bit_cnt;
  logic [DATA_WIDTH-1:0]   shreg;
`ifdef UART_TX_SCHED_PARITY_EN
  logic                    par;
`endif

  logic [DATA_WIDTH-1:0]   req_data [NUM_REQ];
  logic                    gnt_valid;
  logic [ID_W-1:0]         gnt_idx;
  logic [ID_W-1:0]         rr_next;
  logic [DATA_WIDTH-1:0]   gnt_data;
  logic [NUM_REQ-1:0]      gnt_onehot;
  logic [ID_W:0]           probe;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign req_data[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Search starts at the rr pointer and wraps modulo NUM_REQ (not necessarily a power of two).
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    probe     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      probe = {1'b0, rr} + (ID_W+1)'(i);
      if (probe >= (ID_W+1)'(NUM_REQ))
        probe = probe - (ID_W+1)'(NUM_REQ);
      if (!gnt_valid && req_valid_i[probe[ID_W-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = probe[ID_W-1:0];
      end
    end
    gnt_data   = req_data[gnt_idx];
    gnt_onehot = gnt_valid ? (NUM_REQ'(1) << gnt_idx) : '0;
    rr_next    = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  assign req_ready_o = (state == S_IDLE) ? gnt_onehot : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      rr           <= '0;
      baud         <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
`ifdef UART_TX_SCHED_PARITY_EN
      par          <= 1'b0;
`endif
      tx_o         <= 1'b1;
      busy_o       <= 1'b0;
      grant_id_o   <= '0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (gnt_valid) begin
            state      <= S_START;
            shreg      <= gnt_data;
`ifdef UART_TX_SCHED_PARITY_EN
            par        <= ^gnt_data;
`endif
            grant_id_o <= gnt_idx;
            rr         <= rr_next;
            baud       <= '0;
            tx_o       <= 1'b0;
            busy_o     <= 1'b1;
          end
        end
        S_START: begin
          if (baud == BAUD_TC) begin
            state   <= S_DATA;
            baud    <= '0;
            bit_cnt <= '0;
            tx_o    <= shreg[0];
            shreg   <= shreg >> 1;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        S_DATA: begin
          if (baud == BAUD_TC) begin
            baud <= '0;
            if (bit_cnt == BIT_TC) begin
`ifdef UART_TX_SCHED_PARITY_EN
              state <= S_PARITY;
              tx_o  <= par;
`else
              state <= S_STOP;
              tx_o  <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_o    <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
`ifdef UART_TX_SCHED_PARITY_EN
        S_PARITY: begin
          if (baud == BAUD_TC) begin
            state <= S_STOP;
            baud  <= '0;
            tx_o  <= 1'b1;
          end else begin
            baud <= baud + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (baud == BAUD_TC) begin
            state        <= S_IDLE;
            baud         <= '0;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b1;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
